// File: rtl/hold_reset_ctrl_pkg.sv
// Shared types for the long-press reset controller.
// Channel indices map rst_out bits to function modules.
package hold_reset_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    ASSERT,
    WAIT_RELEASE
  } hold_state_t;

  localparam int CH_RELOGIO    = 0;
  localparam int CH_CRONOMETRO = 1;
  localparam int CH_TIMER      = 2;

endpackage

// File: rtl/hold_reset_ctrl_if.sv
// Panel-side bundle of the long-press reset controller.
// master drives button/tick/mask, slave is the controller.
interface hold_reset_ctrl_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 2
);

  logic            tick;
  logic            btn;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] rst_out;
  logic            short_press;
  logic            holding;
  logic [CNT_W-1:0] hold_count;

  modport master (
    output tick,
    output btn,
    output ch_mask,
    input  rst_out,
    input  short_press,
    input  holding,
    input  hold_count
  );

  modport slave (
    input  tick,
    input  btn,
    input  ch_mask,
    output rst_out,
    output short_press,
    output holding,
    output hold_count
  );

endinterface

// File: rtl/hold_reset_ctrl_sync_bit.sv
// Multi-flop synchroniser for one asynchronous panel input.
// Resets to 0 so a held button is seen as a fresh edge.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hold_reset_ctrl.sv
// Long-press reset controller: counts ticks while the
// button is held and then drives masked channel resets.
module hold_reset_ctrl
  import hold_reset_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int HOLD_TICKS  = 2,
  parameter int CNT_W       = $clog2(HOLD_TICKS + 1),
  parameter int PULSE_MODE  = 0,
  parameter int PULSE_LEN   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  hold_reset_ctrl_if.slave bus
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(HOLD_TICKS);
  localparam logic [PW-1:0] PLAST =
    PW'(PULSE_LEN);

  logic btn_s;

  hold_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  rst_out_q, rst_out_d;
  logic             rel_q, rel_d;
  logic             short_q, short_d;
  logic             hold_q, hold_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.btn),
    .q   (btn_s)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    mask_d  = mask_q;
    rel_d   = rel_q;
    short_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) state_d = COUNTING;
      end
      COUNTING: begin
        if (!btn_s) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (bus.tick) begin
          if (count_q == LAST) begin
            state_d = ASSERT;
            count_d = FULL;
            mask_d  = bus.ch_mask;
            pcnt_d  = PW'(1);
            rel_d   = 1'b0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ASSERT: begin
        if (PULSE_MODE == 0) begin
          if (!btn_s) state_d = IDLE;
        end else if (pcnt_q == PLAST) begin
          // a release seen mid-pulse still ends the press
          state_d = (rel_q || !btn_s) ?
                    IDLE : WAIT_RELEASE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
          rel_d  = rel_q | ~btn_s;
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) count_d = '0;
    hold_d    = (state_d == COUNTING);
    rst_out_d = (state_d == ASSERT) ? mask_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pcnt_q    <= '0;
      mask_q    <= '0;
      rst_out_q <= '0;
      rel_q     <= 1'b0;
      short_q   <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      mask_q    <= mask_d;
      rst_out_q <= rst_out_d;
      rel_q     <= rel_d;
      short_q   <= short_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.rst_out     = rst_out_q;
  assign bus.short_press = short_q;
  assign bus.holding     = hold_q;
  assign bus.hold_count  = count_q;

endmodule

// File: tb/tb_hold_reset_ctrl.sv
// Bench for hold_reset_ctrl: three configurations share one
// button/tick stream and are checked against a press model.
module tb_hold_reset_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic tick;
  logic [2:0] mask_a;
  logic [2:0] mask_b;
  logic [4:0] mask_c;

  int checks = 0;
  int errors = 0;
  int b_hi   = 0;

  always #5 clk = ~clk;

  hold_reset_ctrl_if #(.N_CH(3), .CNT_W(2)) ia ();
  hold_reset_ctrl_if #(.N_CH(3), .CNT_W(2)) ib ();
  hold_reset_ctrl_if #(.N_CH(5), .CNT_W(3)) ic ();

  assign ia.btn = btn;
  assign ia.tick = tick;
  assign ia.ch_mask = mask_a;
  assign ib.btn = btn;
  assign ib.tick = tick;
  assign ib.ch_mask = mask_b;
  assign ic.btn = btn;
  assign ic.tick = tick;
  assign ic.ch_mask = mask_c;

  hold_reset_ctrl u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  hold_reset_ctrl #(
    .PULSE_MODE (1),
    .PULSE_LEN  (4)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  hold_reset_ctrl #(
    .N_CH       (5),
    .HOLD_TICKS (5)
  ) u_c (
    .clk   (clk),
    .reset (reset),
    .bus   (ic)
  );

  // press-level model: sh is the 2-cycle synchroniser delay
  typedef struct {
    bit [1:0] sh;
    bit active;
    bit fired;
    bit rel;
    int ticks;
    int left;
    int mask;
    bit short_p;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t step(mdl_t m, int hold,
      bit pm, int plen, bit b_in, bit tk, int msk);
    mdl_t n;
    bit b;
    n = m;
    b = m.sh[1];
    n.sh = {m.sh[0], b_in};
    n.short_p = 1'b0;
    if (!m.active) begin
      if (b) begin
        n.active = 1'b1;
        n.fired = 1'b0;
        n.ticks = 0;
      end
    end else if (!m.fired) begin
      if (!b) begin
        n.active = 1'b0;
        n.short_p = 1'b1;
        n.ticks = 0;
      end else if (tk) begin
        n.ticks = m.ticks + 1;
        if (n.ticks == hold) begin
          n.fired = 1'b1;
          n.mask = msk;
          n.left = plen;
          n.rel = 1'b0;
        end
      end
    end else if (!pm) begin
      if (!b) begin
        n.active = 1'b0;
        n.ticks = 0;
      end
    end else if (m.left > 0) begin
      n.left = m.left - 1;
      n.rel = m.rel | !b;
      if (n.left == 0 && n.rel) begin
        n.active = 1'b0;
        n.ticks = 0;
      end
    end else if (!b) begin
      n.active = 1'b0;
      n.ticks = 0;
    end
    return n;
  endfunction

  function automatic int e_rst(mdl_t m, bit pm);
    if (m.active && m.fired && (!pm || m.left > 0))
      return m.mask;
    return 0;
  endfunction

  function automatic int e_hold(mdl_t m);
    return (m.active && !m.fired) ? 1 : 0;
  endfunction

  function automatic int e_cnt(mdl_t m);
    return m.active ? m.ticks : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
      mc <= '{default: 0};
    end else begin
      ma <= step(ma, 2, 1'b0, 1, btn, tick, int'(mask_a));
      mb <= step(mb, 2, 1'b1, 4, btn, tick, int'(mask_b));
      mc <= step(mc, 5, 1'b0, 1, btn, tick, int'(mask_c));
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("A.rst_out", int'(ia.rst_out), e_rst(ma, 1'b0));
      chk("A.short", int'(ia.short_press), int'(ma.short_p));
      chk("A.holding", int'(ia.holding), e_hold(ma));
      chk("A.count", int'(ia.hold_count), e_cnt(ma));
      chk("B.rst_out", int'(ib.rst_out), e_rst(mb, 1'b1));
      chk("B.short", int'(ib.short_press), int'(mb.short_p));
      chk("B.holding", int'(ib.holding), e_hold(mb));
      chk("B.count", int'(ib.hold_count), e_cnt(mb));
      chk("C.rst_out", int'(ic.rst_out), e_rst(mc, 1'b0));
      chk("C.short", int'(ic.short_press), int'(mc.short_p));
      chk("C.holding", int'(ic.holding), e_hold(mc));
      chk("C.count", int'(ic.hold_count), e_cnt(mc));
      if (ib.rst_out != 3'b000) b_hi++;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  int b0;

  initial begin
    reset = 1'b1;
    btn = 1'b0;
    tick = 1'b0;
    mask_a = 3'b000;
    mask_b = 3'b000;
    mask_c = 5'b00000;
    cyc(2);
    chk("rst.A.rst_out", int'(ia.rst_out), 0);
    chk("rst.A.short", int'(ia.short_press), 0);
    chk("rst.A.holding", int'(ia.holding), 0);
    chk("rst.C.count", int'(ic.hold_count), 0);
    reset = 1'b0;
    cyc(2);

    // long press: level fire, pulse fire, 5-tick fire
    mask_a = 3'b111;
    mask_b = 3'b010;
    mask_c = 5'b10101;
    btn = 1'b1;
    cyc(4);
    chk("p1.A.holding", int'(ia.holding), 1);
    do_tick();
    chk("p1.A.count1", int'(ia.hold_count), 1);
    cyc(3);
    b0 = b_hi;
    do_tick();
    chk("p1.A.fire", int'(ia.rst_out), 7);
    chk("p1.A.count2", int'(ia.hold_count), 2);
    chk("p1.B.fire", int'(ib.rst_out), 2);
    chk("p1.C.count2", int'(ic.hold_count), 2);
    chk("p1.model.A", e_rst(ma, 1'b0), 7);
    repeat (3) begin
      cyc(3);
      do_tick();
    end
    chk("p1.C.fire", int'(ic.rst_out), 21);
    chk("p1.C.sat", int'(ic.hold_count), 5);
    chk("p1.B.done", int'(ib.rst_out), 0);
    chk("p1.B.len", b_hi - b0, 4);
    cyc(4);
    chk("p1.C.sat2", int'(ic.hold_count), 5);
    btn = 1'b0;
    cyc(2);
    chk("p1.A.still", int'(ia.rst_out), 7);
    cyc(1);
    chk("p1.A.drop", int'(ia.rst_out), 0);
    chk("p1.C.drop", int'(ic.rst_out), 0);
    cyc(2);

    // short press
    btn = 1'b1;
    cyc(4);
    do_tick();
    cyc(2);
    btn = 1'b0;
    cyc(2);
    chk("p2.short.pre", int'(ia.short_press), 0);
    cyc(1);
    chk("p2.short", int'(ia.short_press), 1);
    chk("p2.count", int'(ia.hold_count), 0);
    chk("p2.rst", int'(ia.rst_out), 0);
    cyc(1);
    chk("p2.short.end", int'(ia.short_press), 0);
    cyc(2);

    // release on the same clk as the 2nd tick
    btn = 1'b1;
    cyc(4);
    do_tick();
    cyc(2);
    btn = 1'b0;
    cyc(2);
    do_tick();
    chk("p3.short", int'(ia.short_press), 1);
    chk("p3.A.rst", int'(ia.rst_out), 0);
    chk("p3.B.rst", int'(ib.rst_out), 0);
    cyc(3);

    // mask changed while asserted
    mask_a = 3'b001;
    btn = 1'b1;
    cyc(4);
    do_tick();
    cyc(1);
    do_tick();
    chk("p4.fire", int'(ia.rst_out), 1);
    mask_a = 3'b100;
    cyc(3);
    chk("p4.latched", int'(ia.rst_out), 1);
    btn = 1'b0;
    cyc(5);

    // async reset while asserted, button kept held
    mask_a = 3'b110;
    btn = 1'b1;
    cyc(4);
    do_tick();
    cyc(1);
    do_tick();
    chk("p5.fire", int'(ia.rst_out), 6);
    reset = 1'b1;
    #1;
    chk("p5.rst.A", int'(ia.rst_out), 0);
    chk("p5.rst.hold", int'(ia.holding), 0);
    chk("p5.rst.count", int'(ia.hold_count), 0);
    chk("p5.rst.B", int'(ib.rst_out), 0);
    cyc(1);
    reset = 1'b0;
    cyc(4);
    chk("p5.again.hold", int'(ia.holding), 1);
    do_tick();
    chk("p5.again.nofire", int'(ia.rst_out), 0);
    cyc(1);
    do_tick();
    chk("p5.again.fire", int'(ia.rst_out), 6);
    btn = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hold_reset_ctrl.md
Name: hold_reset_ctrl

Overview:
Parametrised long-press reset controller. Synchronises the front-panel reset button and counts 1-second tick strobes while the button is held. When the hold time is reached, it drives per-channel reset lines to the clock, stopwatch, timer and any future function modules. Adds channel masking, level/pulse output modes, short-press detection and hold-progress status.

Parameters:
N_CH, 3, number of reset output channels (bit0 relogio, bit1 cronometro, bit2 timer); >=1
HOLD_TICKS, 2, tick strobes the button must stay held before reset fires; >=1
CNT_W, $clog2(HOLD_TICKS+1), width of the hold counter and the hold_count port
PULSE_MODE, 0, 0 = level (rst_out held while button held), 1 = single pulse per press
PULSE_LEN, 1, rst_out pulse length in clk cycles when PULSE_MODE=1; >=1
SYNC_STAGES, 2, flops in the btn synchroniser; >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset of this block
tick  in  1  one-clk-wide 1 Hz enable strobe
btn  in  1  raw reset button, asynchronous, active-high
ch_mask  in  N_CH  channels to reset; sampled on entry to ASSERT
rst_out  out  N_CH  registered per-channel reset, active-high
short_press  out  1  one-clk pulse on release before the threshold
holding  out  1  high while in COUNTING
hold_count  out  CNT_W  ticks counted in the current press, saturates at HOLD_TICKS

Behaviour:
- Reset (async, active-high) clears all state: synchroniser flops 0, state IDLE, count 0, pulse counter 0, latched mask 0. rst_out=0, short_press=0, holding=0, hold_count=0.
- btn passes through a SYNC_STAGES flop chain to give btn_s. All decisions use btn_s only.
- State IDLE:
  - count=0.
  - btn_s=1 -> COUNTING. count is not incremented in this cycle, even if tick=1.
- State COUNTING, evaluated per clk:
  - btn_s=0 -> IDLE, short_press=1 for the next cycle, count cleared. Release wins over a simultaneous tick.
  - btn_s=1 and tick=1 and count==HOLD_TICKS-1 -> ASSERT, count<=HOLD_TICKS, mask_q<=ch_mask.
  - btn_s=1 and tick=1 otherwise -> count<=count+1.
- State ASSERT:
  - Level mode: rst_out=mask_q every cycle while btn_s=1. btn_s=0 -> IDLE; rst_out drops the following cycle.
  - Pulse mode: rst_out=mask_q for exactly PULSE_LEN cycles, then -> WAIT_RELEASE. A release during the pulse does not shorten it; it ends the press, so the FSM goes to IDLE once the pulse completes.
- State WAIT_RELEASE (pulse mode only):
  - rst_out=0.
  - btn_s=0 -> IDLE.
  - Continued holding never re-fires.
- Latency: rst_out first goes high on the clk after the qualifying tick. From a btn edge that is asynchronous to the tick, add SYNC_STAGES cycles.
- Output timing:
  - holding = (state==COUNTING), registered.
  - hold_count = count.
  - All outputs are registered; no combinational path from any input to any output.
- ch_mask changes after entry to ASSERT are ignored until the next press. ch_mask=0 still runs the FSM, with rst_out=0.
- Ticks are ignored outside COUNTING. The count never wraps; it saturates at HOLD_TICKS.
- Reset asserted mid-press returns the block to IDLE immediately. A button still held afterwards starts a fresh press; in level mode it never produces a glitch on rst_out.

Decomposition:
- Package hold_reset_pkg holds:
  - typedef enum logic [1:0] {IDLE, COUNTING, ASSERT, WAIT_RELEASE} hold_state_t;
  - localparam channel indices CH_RELOGIO=0, CH_CRONOMETRO=1, CH_TIMER=2.
- Sub-module sync_bit (parameter STAGES, async active-high reset): the btn synchroniser, reusable for other panel buttons.
- FSM, counters and output registers stay in hold_reset_ctrl.

Test Plan:
- Defaults; btn=1 held for 3 ticks, ch_mask=3'b111 -> hold_count 1 then 2; rst_out=3'b111 one clk after the 2nd tick, held until btn_s falls, then 0 the next cycle.
- Defaults; btn held for 1 tick, then released -> short_press single-cycle pulse, rst_out stays 0, hold_count returns to 0.
- PULSE_MODE=1, PULSE_LEN=4, ch_mask=3'b010; btn held for 5 ticks -> rst_out=3'b010 for exactly 4 clks after the 2nd tick, then 0 with no re-fire while btn stays high.
- Release on the same clk as the 2nd tick -> no reset, short_press=1. ch_mask changed 3'b001->3'b100 during ASSERT -> rst_out stays 3'b001.
- Async reset pulsed in ASSERT -> rst_out=0 immediately, state IDLE. Btn still held -> new press, fires again after 2 further ticks.
- HOLD_TICKS=5, N_CH=5 -> fires only after the 5th tick; hold_count saturates at 5.
